// File: rtl/alu_core_if.sv
// alu_core_if: operand/control/result bundle for the execute-stage ALU.
//   ALU_control [3:0]  operation select          (master -> slave)
//   in_A        [31:0] operand A                 (master -> slave)
//   in_B        [31:0] operand B / shift amount  (master -> slave)
//   out         [31:0] registered result         (slave  -> master)
// There is no handshake: every clock cycle carries a valid operation.
interface alu_core_if;
    logic [3:0]  ALU_control;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [31:0] out;

    modport master (
        output ALU_control,
        output in_A,
        output in_B,
        input  out
    );

    modport slave (
        input  ALU_control,
        input  in_A,
        input  in_B,
        output out
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: 32-bit registered arithmetic/logic unit for the execute stage.
// One of sixteen operations is selected by ALU_control and applied to
// in_A/in_B. The result is registered and appears on out one cycle later.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; forces out to zero immediately
//   bus    alu_core_if.slave: ALU_control, in_A, in_B in; out out
module alu_core (
    input  logic       clk,
    input  logic       rst_n,
    alu_core_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_NOR   = 4'd10,
        OP_MUL   = 4'd11,
        OP_PASSA = 4'd12,
        OP_PASSB = 4'd13,
        OP_LUI   = 4'd14,
        OP_ZERO  = 4'd15
    } alu_op_e;

    alu_op_e     op;
    logic [4:0]  shamt;
    logic [31:0] out_d;
    logic [31:0] out_q;

    assign op    = alu_op_e'(bus.ALU_control);
    // Only the low five bits of in_B are a shift amount, so shifts never
    // reach 32 or more.
    assign shamt = bus.in_B[4:0];

    always_comb begin
        out_d = '0;
        unique case (op)
            OP_ADD:   out_d = bus.in_A + bus.in_B;
            OP_SUB:   out_d = bus.in_A - bus.in_B;
            OP_AND:   out_d = bus.in_A & bus.in_B;
            OP_OR:    out_d = bus.in_A | bus.in_B;
            OP_XOR:   out_d = bus.in_A ^ bus.in_B;
            OP_SLL:   out_d = bus.in_A << shamt;
            OP_SRL:   out_d = bus.in_A >> shamt;
            OP_SRA:   out_d = $unsigned($signed(bus.in_A) >>> shamt);
            OP_SLT:   out_d = {31'd0, $signed(bus.in_A) < $signed(bus.in_B)};
            OP_SLTU:  out_d = {31'd0, bus.in_A < bus.in_B};
            OP_NOR:   out_d = ~(bus.in_A | bus.in_B);
            // Low 32 bits are identical for signed and unsigned operands.
            OP_MUL:   out_d = bus.in_A * bus.in_B;
            OP_PASSA: out_d = bus.in_A;
            OP_PASSB: out_d = bus.in_B;
            OP_LUI:   out_d = {bus.in_B[15:0], 16'd0};
            OP_ZERO:  out_d = '0;
            default:  out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed-vector bench for alu_core with a queue scoreboard.
// Stimulus drives operands on the falling edge and, after the rising edge
// that samples them, pushes the hand-computed result. The monitor pops and
// compares on every falling edge while out of reset.
module tb_alu_core;

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    alu_core_if bus ();

    alu_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Present one operation for one cycle and queue its expected result.
    task automatic issue(input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input string tag);
        exp_t e;
        @(negedge clk);
        bus.ALU_control = ctl;
        bus.in_A        = a;
        bus.in_B        = b;
        @(posedge clk);
        e.exp = exp;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.tag, bus.out, e.exp);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.ALU_control = 4'd0;
        bus.in_A        = 32'd254;
        bus.in_B        = 32'd129;

        // Reset value before any clock edge, and held across edges.
        #2;
        check("reset_no_edge", bus.out, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", bus.out, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_release", bus.out, 32'd0);
        @(posedge clk);
        e.exp = 32'd383;
        e.tag = "first_add";
        exp_q.push_back(e);

        // Basic sweep 0..7 back to back.
        issue(4'd0, 32'd254, 32'd129, 32'd383, "add");
        issue(4'd1, 32'd254, 32'd129, 32'd125, "sub");
        issue(4'd2, 32'd254, 32'd129, 32'd128, "and");
        issue(4'd3, 32'd254, 32'd129, 32'd255, "or");
        issue(4'd4, 32'd254, 32'd129, 32'd127, "xor");
        issue(4'd5, 32'd254, 32'd129, 32'd508, "sll");
        issue(4'd6, 32'd254, 32'd129, 32'd127, "srl");
        issue(4'd7, 32'd254, 32'd129, 32'd127, "sra");

        // Codes 8..15.
        issue(4'd8,  32'd254, 32'd129, 32'd0,          "slt");
        issue(4'd9,  32'd254, 32'd129, 32'd0,          "sltu");
        issue(4'd10, 32'd254, 32'd129, 32'hFFFFFF00,   "nor");
        issue(4'd11, 32'd254, 32'd129, 32'd32766,      "mul");
        issue(4'd12, 32'd254, 32'd129, 32'd254,        "passa");
        issue(4'd13, 32'd254, 32'd129, 32'd129,        "passb");
        issue(4'd14, 32'd254, 32'd129, 32'h00810000,   "lui");
        issue(4'd15, 32'd254, 32'd129, 32'd0,          "zero");

        // Signed behaviour around the sign bit.
        issue(4'd7, 32'h80000000, 32'd1, 32'hC0000000, "sra_neg");
        issue(4'd6, 32'h80000000, 32'd1, 32'h40000000, "srl_neg");
        issue(4'd8, 32'h80000000, 32'd1, 32'd1,        "slt_neg");
        issue(4'd9, 32'h80000000, 32'd1, 32'd0,        "sltu_neg");
        issue(4'd8, 32'd5, 32'hFFFFFFFF, 32'd0,        "slt_pos_vs_m1");
        issue(4'd9, 32'd5, 32'hFFFFFFFF, 32'd1,        "sltu_small");
        issue(4'd7, 32'h80000010, 32'd4, 32'hF8000001, "sra_by4");

        // Wrap-around.
        issue(4'd0,  32'hFFFFFFFF, 32'd1,     32'd0,        "add_wrap");
        issue(4'd1,  32'd0,        32'd1,     32'hFFFFFFFF, "sub_wrap");
        issue(4'd11, 32'h10000,    32'h10000, 32'd0,        "mul_wrap");
        issue(4'd11, 32'hFFFFFFFF, 32'd3,     32'hFFFFFFFD, "mul_neg");

        // Shift amount masking and LUI ignoring high bits of in_B.
        issue(4'd5,  32'd1, 32'd33,        32'd2,          "sll_mask");
        issue(4'd6,  32'h80000000, 32'd63, 32'd1,          "srl_mask");
        issue(4'd14, 32'd0, 32'hABCD1234,  32'h12340000,   "lui_hi");

        // Mid-stream reset: in-flight result lost, resumes with current inputs.
        issue(4'd0, 32'd7, 32'd8, 32'd15, "pre_reset");
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midstream_reset", bus.out, 32'd0);
        bus.ALU_control = 4'd3;
        bus.in_A        = 32'h000000F0;
        bus.in_B        = 32'h0000000F;
        #1;
        rst_n = 1'b1;
        #1;
        check("midstream_held", bus.out, 32'd0);
        @(posedge clk);
        e.exp = 32'h000000FF;
        e.tag = "resume_or";
        exp_q.push_back(e);
        issue(4'd1, 32'd10, 32'd3, 32'd7, "resume_sub");

        // Drain the scoreboard, bounded.
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
